// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/flush controller.
package pipe_ctrl_pkg;

    localparam int unsigned REG_IDX_WIDTH = 5;
    localparam logic [REG_IDX_WIDTH-1:0] REG_X0 = '0;

    typedef enum logic [1:0] {
        PCTL_RUN   = 2'd0,
        PCTL_FLUSH = 2'd1,
        PCTL_DRAIN = 2'd2
    } pctl_state_t;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_flush;
        logic ex_mem_flush;
    } ctrl_t;

    function automatic logic src_hit(
        input logic                     en,
        input logic [REG_IDX_WIDTH-1:0] src,
        input logic [REG_IDX_WIDTH-1:0] dst
    );
        return en && (src == dst);
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_cmp.sv
// Load-use comparator: decode sources against a load destination sitting in EX.
module hazard_cmp
    import pipe_ctrl_pkg::*;
(
    input  logic                     dec_valid,
    input  logic [REG_IDX_WIDTH-1:0] rs1_idx,
    input  logic [REG_IDX_WIDTH-1:0] rs2_idx,
    input  logic                     rs1_en,
    input  logic                     rs2_en,
    input  logic                     ex_valid,
    input  logic                     ex_is_load,
    input  logic [REG_IDX_WIDTH-1:0] rd_idx,
    input  logic                     rd_en,
    output logic                     luh
);

    logic load_writes;
    logic src_match;

    // x0 is hardwired, so a load targeting it never produces a hazard.
    assign load_writes = ex_valid & ex_is_load & rd_en & (rd_idx != REG_X0);
    assign src_match   = src_hit(rs1_en, rs1_idx, rd_idx) | src_hit(rs2_en, rs2_idx, rd_idx);
    assign luh         = dec_valid & load_writes & src_match;

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard and flush controller: stall/bubble controls for PC, IF/ID, ID/EX, EX/MEM.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     dec_valid_i,
    input  logic [REG_IDX_WIDTH-1:0] dec_rs1_idx_i,
    input  logic [REG_IDX_WIDTH-1:0] dec_rs2_idx_i,
    input  logic                     dec_rs1_en_i,
    input  logic                     dec_rs2_en_i,
    input  logic                     dec_is_csr_i,
    input  logic                     ex_valid_i,
    input  logic                     ex_is_load_i,
    input  logic [REG_IDX_WIDTH-1:0] ex_rd_idx_i,
    input  logic                     ex_rd_en_i,
    input  logic                     ex_busy_i,
    input  logic                     ex_redirect_i,
    input  logic                     mem_valid_i,
    output logic                     pc_stall_o,
    output logic                     if_id_stall_o,
    output logic                     if_id_flush_o,
    output logic                     id_ex_stall_o,
    output logic                     id_ex_flush_o,
    output logic                     ex_mem_flush_o,
    output logic [CNT_WIDTH-1:0]     stall_cnt_o,
    output logic [CNT_WIDTH-1:0]     flush_cnt_o
);

    localparam logic [2:0] FCNT_LOAD = 3'(FLUSH_CYCLES);

    pctl_state_t          state;
    pctl_state_t          state_next;
    logic [2:0]           fcnt;
    logic [2:0]           fcnt_next;
    logic                 luh;
    logic                 csrh;
    logic                 occupied;
    logic                 redirect_taken;
    ctrl_t                ctrl;
    logic [CNT_WIDTH-1:0] stall_cnt;
    logic [CNT_WIDTH-1:0] flush_cnt;

    hazard_cmp u_hazard_cmp (
        .dec_valid  (dec_valid_i),
        .rs1_idx    (dec_rs1_idx_i),
        .rs2_idx    (dec_rs2_idx_i),
        .rs1_en     (dec_rs1_en_i),
        .rs2_en     (dec_rs2_en_i),
        .ex_valid   (ex_valid_i),
        .ex_is_load (ex_is_load_i),
        .rd_idx     (ex_rd_idx_i),
        .rd_en      (ex_rd_en_i),
        .luh        (luh)
    );

    assign occupied = ex_valid_i | mem_valid_i;
    assign csrh     = dec_valid_i & dec_is_csr_i & occupied;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= PCTL_RUN;
            fcnt  <= '0;
        end else begin
            state <= state_next;
            fcnt  <= fcnt_next;
        end
    end

    // Priority chain: busy > redirect > refill > load-use > CSR drain > drain release.
    always_comb begin
        ctrl           = '0;
        state_next     = state;
        fcnt_next      = fcnt;
        redirect_taken = 1'b0;

        if (ex_busy_i) begin
            ctrl.pc_stall     = 1'b1;
            ctrl.if_id_stall  = 1'b1;
            ctrl.id_ex_stall  = 1'b1;
            ctrl.ex_mem_flush = 1'b1;
        end else if (ex_redirect_i) begin
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
            redirect_taken   = 1'b1;
            if (FLUSH_CYCLES != 0) begin
                state_next = PCTL_FLUSH;
                fcnt_next  = FCNT_LOAD;
            end else begin
                state_next = PCTL_RUN;
            end
        end else if (state == PCTL_FLUSH) begin
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
            if (fcnt <= 3'd1) begin
                fcnt_next  = '0;
                state_next = PCTL_RUN;
            end else begin
                fcnt_next = fcnt - 3'd1;
            end
        end else if (luh) begin
            ctrl.pc_stall    = 1'b1;
            ctrl.if_id_stall = 1'b1;
            ctrl.id_ex_flush = 1'b1;
        end else if (csrh || (state == PCTL_DRAIN && occupied)) begin
            ctrl.pc_stall    = 1'b1;
            ctrl.if_id_stall = 1'b1;
            ctrl.id_ex_flush = 1'b1;
            state_next       = PCTL_DRAIN;
        end else if (state == PCTL_DRAIN) begin
            state_next = PCTL_RUN;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (ctrl.pc_stall) begin
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            end
            if (redirect_taken) begin
                flush_cnt <= flush_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign pc_stall_o     = ctrl.pc_stall;
    assign if_id_stall_o  = ctrl.if_id_stall;
    assign if_id_flush_o  = ctrl.if_id_flush;
    assign id_ex_stall_o  = ctrl.id_ex_stall;
    assign id_ex_flush_o  = ctrl.id_ex_flush;
    assign ex_mem_flush_o = ctrl.ex_mem_flush;
    assign stall_cnt_o    = stall_cnt;
    assign flush_cnt_o    = flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: driver pushes model expectations, monitor compares at negedge.
module tb_pipe_ctrl;

    localparam int FC = 1;
    localparam int CW = 8;

    typedef struct packed {
        logic       dec_valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rs1_en;
        logic       rs2_en;
        logic       dec_csr;
        logic       ex_valid;
        logic       ex_load;
        logic [4:0] rd;
        logic       rd_en;
        logic       busy;
        logic       redirect;
        logic       mem_valid;
    } stim_t;

    typedef struct packed {
        logic [5:0]    ctrl;
        logic [CW-1:0] stall_cnt;
        logic [CW-1:0] flush_cnt;
    } exp_t;

    // ctrl bit order: pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush
    localparam logic [5:0] C_BUSY   = 6'b110101;
    localparam logic [5:0] C_FLUSH  = 6'b001010;
    localparam logic [5:0] C_BUBBLE = 6'b110010;

    logic          clk;
    logic          rst;
    logic          dec_valid;
    logic [4:0]    dec_rs1_idx;
    logic [4:0]    dec_rs2_idx;
    logic          dec_rs1_en;
    logic          dec_rs2_en;
    logic          dec_is_csr;
    logic          ex_valid;
    logic          ex_is_load;
    logic [4:0]    ex_rd_idx;
    logic          ex_rd_en;
    logic          ex_busy;
    logic          ex_redirect;
    logic          mem_valid;
    logic          pc_stall;
    logic          if_id_stall;
    logic          if_id_flush;
    logic          id_ex_stall;
    logic          id_ex_flush;
    logic          ex_mem_flush;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    int   total = 0;
    int   bad   = 0;
    exp_t expq[$];

    // Reference model state: remaining refill slots, pending CSR, event tallies.
    int m_refill = 0;
    bit m_drain  = 0;
    int m_stall  = 0;
    int m_flush  = 0;

    pipe_ctrl #(
        .FLUSH_CYCLES (FC),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .dec_valid_i    (dec_valid),
        .dec_rs1_idx_i  (dec_rs1_idx),
        .dec_rs2_idx_i  (dec_rs2_idx),
        .dec_rs1_en_i   (dec_rs1_en),
        .dec_rs2_en_i   (dec_rs2_en),
        .dec_is_csr_i   (dec_is_csr),
        .ex_valid_i     (ex_valid),
        .ex_is_load_i   (ex_is_load),
        .ex_rd_idx_i    (ex_rd_idx),
        .ex_rd_en_i     (ex_rd_en),
        .ex_busy_i      (ex_busy),
        .ex_redirect_i  (ex_redirect),
        .mem_valid_i    (mem_valid),
        .pc_stall_o     (pc_stall),
        .if_id_stall_o  (if_id_stall),
        .if_id_flush_o  (if_id_flush),
        .id_ex_stall_o  (id_ex_stall),
        .id_ex_flush_o  (id_ex_flush),
        .ex_mem_flush_o (ex_mem_flush),
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, want);
        end
    endtask

    function automatic logic [5:0] dut_ctrl();
        return {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush};
    endfunction

    task automatic model_step(input stim_t s, output exp_t e);
        bit         lu;
        bit         occ;
        bit         accepted;
        logic [5:0] c;
        lu  = s.dec_valid && s.ex_valid && s.ex_load && s.rd_en && (s.rd != 0) &&
              ((s.rs1_en && s.rs1 == s.rd) || (s.rs2_en && s.rs2 == s.rd));
        occ = s.ex_valid || s.mem_valid;
        accepted = 0;
        c = '0;
        if (s.busy) begin
            c = C_BUSY;
        end else if (s.redirect) begin
            c = C_FLUSH;
            accepted = 1;
            m_refill = FC;
            m_drain = 0;
        end else if (m_refill > 0) begin
            c = C_FLUSH;
            m_refill--;
        end else if (lu) begin
            c = C_BUBBLE;
        end else if ((s.dec_valid && s.dec_csr && occ) || (m_drain && occ)) begin
            c = C_BUBBLE;
            m_drain = 1;
        end else begin
            m_drain = 0;
        end
        e.ctrl = c;
        e.stall_cnt = CW'(m_stall);
        e.flush_cnt = CW'(m_flush);
        if (c[5]) m_stall = (m_stall + 1) % (1 << CW);
        if (accepted) m_flush = (m_flush + 1) % (1 << CW);
    endtask

    task automatic apply(input stim_t s);
        dec_valid   = s.dec_valid;
        dec_rs1_idx = s.rs1;
        dec_rs2_idx = s.rs2;
        dec_rs1_en  = s.rs1_en;
        dec_rs2_en  = s.rs2_en;
        dec_is_csr  = s.dec_csr;
        ex_valid    = s.ex_valid;
        ex_is_load  = s.ex_load;
        ex_rd_idx   = s.rd;
        ex_rd_en    = s.rd_en;
        ex_busy     = s.busy;
        ex_redirect = s.redirect;
        mem_valid   = s.mem_valid;
    endtask

    task automatic drive(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(s);
        model_step(s, e);
        expq.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("ctrl", 32'(dut_ctrl()), 32'(e.ctrl));
                check("stall_cnt", 32'(stall_cnt), 32'(e.stall_cnt));
                check("flush_cnt", 32'(flush_cnt), 32'(e.flush_cnt));
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        stim_t s;
        exp_t  e;
        rst = 1'b1;
        apply('0);
        #2;
        check("reset_ctrl", 32'(dut_ctrl()), 32'h0);
        check("reset_stall_cnt", 32'(stall_cnt), 32'h0);
        check("reset_flush_cnt", 32'(flush_cnt), 32'h0);

        // Load-use: lw x5 in EX, add x6,x5,x1 in ID; then the bubble reaches EX.
        s = '0;
        s.dec_valid = 1; s.rs1 = 5; s.rs1_en = 1; s.rs2 = 1; s.rs2_en = 1;
        s.ex_valid = 1; s.ex_load = 1; s.rd = 5; s.rd_en = 1;
        drive(s);
        s.ex_valid = 0; s.ex_load = 0; s.mem_valid = 1;
        drive(s);
        drive('0);

        // Load to x0, and an rs2 match with rs2 disabled.
        s = '0;
        s.dec_valid = 1; s.rs1 = 0; s.rs1_en = 1;
        s.ex_valid = 1; s.ex_load = 1; s.rd = 0; s.rd_en = 1;
        drive(s);
        s.rs1 = 3; s.rs2 = 7; s.rs2_en = 0; s.rd = 7;
        drive(s);

        // Redirect pulse, then a second redirect landing inside the refill window.
        s = '0; s.redirect = 1;
        drive(s);
        repeat (3) drive('0);
        drive(s);
        drive(s);
        repeat (3) drive('0);

        // Busy holds off a pending redirect for four cycles.
        s = '0; s.busy = 1; s.redirect = 1;
        repeat (4) drive(s);
        s.busy = 0;
        drive(s);
        repeat (3) drive('0);

        // CSR drain: EX clears after one cycle, MEM after two.
        s = '0; s.dec_valid = 1; s.dec_csr = 1; s.ex_valid = 1; s.mem_valid = 1;
        drive(s);
        s.ex_valid = 0;
        drive(s);
        s.mem_valid = 0;
        drive(s);
        drive('0);

        // Redirect arriving while draining abandons the CSR.
        s = '0; s.dec_valid = 1; s.dec_csr = 1; s.ex_valid = 1; s.mem_valid = 1;
        drive(s);
        s = '0; s.redirect = 1; s.mem_valid = 1;
        drive(s);
        s.redirect = 0;
        drive(s);
        repeat (3) drive('0);

        for (int unsigned i = 0; i < 3000; i++) begin
            s = '0;
            s.dec_valid = ($urandom_range(0, 3) != 0);
            s.rs1       = 5'($urandom_range(0, 3));
            s.rs2       = 5'($urandom_range(0, 3));
            s.rs1_en    = ($urandom_range(0, 3) != 0);
            s.rs2_en    = ($urandom_range(0, 1) != 0);
            s.dec_csr   = ($urandom_range(0, 5) == 0);
            s.ex_valid  = ($urandom_range(0, 2) != 0);
            s.ex_load   = ($urandom_range(0, 1) != 0);
            s.rd        = 5'($urandom_range(0, 3));
            s.rd_en     = ($urandom_range(0, 3) != 0);
            s.busy      = ($urandom_range(0, 9) == 0);
            s.redirect  = ($urandom_range(0, 9) == 0);
            s.mem_valid = ($urandom_range(0, 1) != 0);
            drive(s);
        end

        // Asynchronous reset while in the refill window with counters nonzero.
        s = '0; s.redirect = 1;
        drive(s);
        @(posedge clk);
        #1;
        apply('0);
        model_step('0, e);
        check("pre_rst_ctrl", 32'(dut_ctrl()), 32'(e.ctrl));
        check("pre_rst_flush_cnt", 32'(flush_cnt), 32'(e.flush_cnt));
        rst = 1'b1;
        #1;
        check("async_rst_ctrl", 32'(dut_ctrl()), 32'h0);
        check("async_rst_stall_cnt", 32'(stall_cnt), 32'h0);
        check("async_rst_flush_cnt", 32'(flush_cnt), 32'h0);
        m_refill = 0;
        m_drain = 0;
        m_stall = 0;
        m_flush = 0;
        expq.push_back('0);
        drive('0);
        s = '0; s.redirect = 1;
        drive(s);
        repeat (3) drive('0);

        @(posedge clk);
        @(negedge clk);
        #1;
        check("queue_drained", 32'(expq.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
